// File: rtl/gpr_sb.sv
// gpr_sb: register file with per-register busy scoreboard. Reads and rsv_ok are combinational, and every state update lands on the clk2 edge.
// There is no backpressure; a rejected reservation changes no state. Define GPR_SB_BYPASS_EN to enable same-cycle write-to-read forwarding.
module gpr_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk2,
  input  logic            rst_n,
  input  logic [$clog2(NREG)-1:0] rs1_addr,
  input  logic [$clog2(NREG)-1:0] rs2_addr,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [$clog2(NREG)-1:0] wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rsv_en,
  input  logic [$clog2(NREG)-1:0] rsv_addr,
  output logic            rsv_ok,
  output logic [$clog2(NREG):0]   busy_cnt
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     busy_cnt_q;
  logic [AW:0]     busy_cnt_d;

  logic            wr_fire;
  logic            rsv_fire;
  logic            cnt_inc;
  logic            cnt_dec;
  logic [XLEN-1:0] rs1_stored;
  logic [XLEN-1:0] rs2_stored;

  assign wr_fire  = wr_en && (wr_addr != '0);

  // A writeback to the requested register frees it in the same cycle.
  assign rsv_ok   = rsv_en && ((rsv_addr == '0) || !busy_q[rsv_addr] ||
                               (wr_en && (wr_addr == rsv_addr)));
  assign rsv_fire = rsv_ok && (rsv_addr != '0);

  always_comb begin
    busy_d = busy_q;
    if (wr_fire) busy_d[wr_addr] = 1'b0;
    if (rsv_fire) busy_d[rsv_addr] = 1'b1;
  end

  // Count tracks busy_d incrementally. A write and a reservation to the same busy register cancel out.
  assign cnt_inc    = rsv_fire && !busy_q[rsv_addr];
  assign cnt_dec    = wr_fire && busy_q[wr_addr] && !(rsv_fire && (rsv_addr == wr_addr));
  assign busy_cnt_d = busy_cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_fire) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign rs1_stored = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
  assign rs2_stored = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
  assign busy_cnt   = busy_cnt_q;

`ifdef GPR_SB_BYPASS_EN
  logic byp1;
  logic byp2;

  assign byp1     = wr_fire && (wr_addr == rs1_addr);
  assign byp2     = wr_fire && (wr_addr == rs2_addr);
  assign rs1      = byp1 ? wr_data : rs1_stored;
  assign rs2      = byp2 ? wr_data : rs2_stored;
  assign rs1_busy = byp1 ? 1'b0 : busy_q[rs1_addr];
  assign rs2_busy = byp2 ? 1'b0 : busy_q[rs2_addr];
`else
  assign rs1      = rs1_stored;
  assign rs2      = rs2_stored;
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
`endif

  a_cnt_matches : assert property (@(posedge clk2) disable iff (!rst_n)
    busy_cnt_q == (AW+1)'($countones(busy_q)));
  a_x0_idle : assert property (@(posedge clk2) disable iff (!rst_n) !busy_q[0]);

endmodule

// File: tb/tb_gpr_sb.sv
// Directed bench for gpr_sb: reset, read/write, reservation, same-cycle write+reserve, bypass and async reset.
module tb_gpr_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk2;
  logic            rst_n;
  logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, rsv_addr;
  logic [XLEN-1:0] rs1, rs2, wr_data;
  logic            rs1_busy, rs2_busy, wr_en, rsv_en, rsv_ok;
  logic [AW:0]     busy_cnt;

  int checks   = 0;
  int failures = 0;

  gpr_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk2(clk2), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .busy_cnt(busy_cnt)
  );

  initial begin
    clk2 = 1'b0;
    forever #5 clk2 = ~clk2;
  end

  // Advance to 1ns after the next rising edge, then clear the strobes.
  task automatic tick();
    @(posedge clk2);
    #1;
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = 1'b0; rsv_en = 1'b0;
    wr_addr = '0; wr_data = '0; rsv_addr = '0;
    rs1_addr = '0; rs2_addr = '0;
    #12;
    checks++;
    if (busy_cnt !== 6'd0) begin
      failures++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NREG; i++) begin
      rs1_addr = AW'(i);
      rs2_addr = AW'(NREG - 1 - i);
      #1;
      checks++;
      if (rs1 !== 32'd0 || rs2 !== 32'd0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_read addr=%0d got rs1=%h rs2=%h b1=%b b2=%b exp=0", i, rs1, rs2, rs1_busy, rs2_busy);
      end
    end
    checks++;
    if (busy_cnt !== 6'd0) begin
      failures++; $display("FAIL reset_busy_cnt_after got=%0d exp=0", busy_cnt);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    rs1_addr = 5'd5;
    #1;
    checks++;
    if (rs1 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL write_x5 got=%h exp=deadbeef", rs1);
    end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    tick();
    rs2_addr = 5'd0;
    #1;
    checks++;
    if (rs2 !== 32'd0) begin
      failures++; $display("FAIL write_x0 got=%h exp=0", rs2);
    end
  endtask

  task automatic test_reserve();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    checks++;
    if (rsv_ok !== 1'b1) begin
      failures++; $display("FAIL rsv_x3_ok got=%b exp=1", rsv_ok);
    end
    tick();
    rs1_addr = 5'd3;
    #1;
    checks++;
    if (busy_cnt !== 6'd1 || rs1_busy !== 1'b1) begin
      failures++; $display("FAIL rsv_x3_state got cnt=%0d busy=%b exp cnt=1 busy=1", busy_cnt, rs1_busy);
    end
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    checks++;
    if (rsv_ok !== 1'b0) begin
      failures++; $display("FAIL rsv_x3_again got=%b exp=0", rsv_ok);
    end
    tick();
    checks++;
    if (busy_cnt !== 6'd1) begin
      failures++; $display("FAIL rsv_reject_cnt got=%0d exp=1", busy_cnt);
    end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd7;
    tick();
    #1;
    checks++;
    if (busy_cnt !== 6'd0 || rs1_busy !== 1'b0 || rs1 !== 32'd7) begin
      failures++; $display("FAIL wb_x3 got cnt=%0d busy=%b data=%h exp cnt=0 busy=0 data=7", busy_cnt, rs1_busy, rs1);
    end
    // Write to a non-busy register must not underflow the count.
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h88;
    tick();
    checks++;
    if (busy_cnt !== 6'd0) begin
      failures++; $display("FAIL wr_idle_cnt got=%0d exp=0", busy_cnt);
    end
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    checks++;
    if (rsv_ok !== 1'b1) begin
      failures++; $display("FAIL rsv_x0_ok got=%b exp=1", rsv_ok);
    end
    tick();
    rs2_addr = 5'd0;
    #1;
    checks++;
    if (busy_cnt !== 6'd0 || rs2_busy !== 1'b0) begin
      failures++; $display("FAIL rsv_x0_state got cnt=%0d busy=%b exp 0/0", busy_cnt, rs2_busy);
    end
  endtask

  task automatic test_same_cycle();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    tick();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd9;
    rsv_en = 1'b1; rsv_addr = 5'd4;
    #1;
    checks++;
    if (rsv_ok !== 1'b1) begin
      failures++; $display("FAIL same_rsv_ok got=%b exp=1", rsv_ok);
    end
    tick();
    rs1_addr = 5'd4;
    #1;
    checks++;
    if (rs1 !== 32'd9 || rs1_busy !== 1'b1 || busy_cnt !== 6'd1) begin
      failures++; $display("FAIL same_state got data=%h busy=%b cnt=%0d exp 9/1/1", rs1, rs1_busy, busy_cnt);
    end
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd10;
    tick();
    checks++;
    if (busy_cnt !== 6'd0) begin
      failures++; $display("FAIL same_release_cnt got=%0d exp=0", busy_cnt);
    end
  endtask

  task automatic test_bypass();
    rsv_en = 1'b1; rsv_addr = 5'd6;
    tick();
    rs1_addr = 5'd6;
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hA5;
    #1;
    checks++;
`ifdef GPR_SB_BYPASS_EN
    if (rs1 !== 32'hA5 || rs1_busy !== 1'b0) begin
      failures++; $display("FAIL bypass_same got data=%h busy=%b exp a5/0", rs1, rs1_busy);
    end
`else
    if (rs1 !== 32'h0 || rs1_busy !== 1'b1) begin
      failures++; $display("FAIL nobypass_same got data=%h busy=%b exp 0/1", rs1, rs1_busy);
    end
`endif
    tick();
    checks++;
    if (rs1 !== 32'hA5 || rs1_busy !== 1'b0 || busy_cnt !== 6'd0) begin
      failures++; $display("FAIL bypass_next got data=%h busy=%b cnt=%0d exp a5/0/0", rs1, rs1_busy, busy_cnt);
    end
  endtask

  task automatic test_async_reset();
    rsv_en = 1'b1; rsv_addr = 5'd1; tick();
    rsv_en = 1'b1; rsv_addr = 5'd2; tick();
    rsv_en = 1'b1; rsv_addr = 5'd7; tick();
    rs1_addr = 5'd7; rs2_addr = 5'd5;
    #1;
    checks++;
    if (busy_cnt !== 6'd3 || rs1_busy !== 1'b1) begin
      failures++; $display("FAIL pre_reset got cnt=%0d busy=%b exp 3/1", busy_cnt, rs1_busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy_cnt !== 6'd0 || rs1_busy !== 1'b0 || rs2 !== 32'd0) begin
      failures++; $display("FAIL async_reset got cnt=%0d busy=%b x5=%h exp 0/0/0", busy_cnt, rs1_busy, rs2);
    end
    rs1_addr = 5'd3; rs2_addr = 5'd6;
    #1;
    checks++;
    if (rs1 !== 32'd0 || rs2 !== 32'd0) begin
      failures++; $display("FAIL async_reset_data got x3=%h x6=%h exp 0/0", rs1, rs2);
    end
    // Strobes held through reset must be discarded.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    @(posedge clk2);
    #2;
    checks++;
    if (rs1 !== 32'd0) begin
      failures++; $display("FAIL reset_wr_discard got=%h exp=0", rs1);
    end
    wr_en = 1'b0;
    @(negedge clk2);
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy_cnt !== 6'd0 || rs1 !== 32'd0) begin
      failures++; $display("FAIL post_reset got cnt=%0d x3=%h exp 0/0", busy_cnt, rs1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reserve();
    test_same_cycle();
    test_bypass();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpr_sb.md
GPR_SB -- requirements
Module: gpr_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width in bits.
REQ-002 SHALL have parameter NREG, default 32, number of registers (power of two, 2 to 64).
REQ-003 SHALL have derived localparam AW = log2(NREG), the address width.
REQ-004 SHALL have port clk2  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rs1_addr  input  AW  read port 1 address.
REQ-007 SHALL have port rs2_addr  input  AW  read port 2 address.
REQ-008 SHALL have port rs1  output  XLEN  read port 1 data (combinational).
REQ-009 SHALL have port rs2  output  XLEN  read port 2 data (combinational).
REQ-010 SHALL have port rs1_busy  output  1  rs1_addr has a pending write.
REQ-011 SHALL have port rs2_busy  output  1  rs2_addr has a pending write.
REQ-012 SHALL have port wr_en  input  1  writeback strobe.
REQ-013 SHALL have port wr_addr  input  AW  writeback address.
REQ-014 SHALL have port wr_data  input  XLEN  writeback data.
REQ-015 SHALL have port rsv_en  input  1  reservation request (instruction issue).
REQ-016 SHALL have port rsv_addr  input  AW  destination register to reserve.
REQ-017 SHALL have port rsv_ok  output  1  reservation accepted this cycle (combinational).
REQ-018 SHALL have port busy_cnt  output  AW+1  number of registers currently busy.

Function
REQ-019 SHALL hold NREG x XLEN storage plus one busy bit per register.
REQ-020 SHALL write wr_data to wr_addr at the rising clk2 edge when wr_en=1 and wr_addr!=0.
REQ-021 SHALL hardwire register 0: reads return 0, writes are ignored, busy is never set.
REQ-022 SHALL clear busy[wr_addr] on a write; a write to a non-busy register updates data only, with no busy_cnt underflow.
REQ-023 SHALL drive rsv_ok = rsv_en and (rsv_addr==0 or not busy[rsv_addr] or (wr_en and wr_addr==rsv_addr)).
REQ-024 SHALL set busy[rsv_addr] at the clock edge when rsv_ok=1 and rsv_addr!=0; a rejected reservation changes no state.
REQ-025 SHALL, when write and reservation target the same address in one cycle, store the data and leave busy=1 (reservation wins).
REQ-026 SHALL keep busy_cnt equal to the population count of the busy bits, updated in the same edge, range 0 to NREG-1.
REQ-027 SHALL drive rs1_busy/rs2_busy from registered busy state; register 0 is always not busy.

Reset
REQ-028 SHALL, while rst_n=0, clear all registers to 0, all busy bits to 0 and busy_cnt to 0 immediately, independent of clk2.
REQ-029 SHALL discard any write or reservation coincident with reset assertion; the first update is at the first rising edge after rst_n=1.

Configuration
REQ-030 SHALL, with macro GPR_SB_BYPASS_EN defined, forward wr_data to rsN and force rsN_busy=0 when wr_en=1, wr_addr==rsN_addr and wr_addr!=0 (same-cycle write-to-read).
REQ-031 SHALL, without GPR_SB_BYPASS_EN, return only stored data and registered busy; the written value is visible the cycle after the write.

Verification
REQ-032 SHALL cover: reset, then read all addresses -> all 0, busy_cnt=0.
REQ-033 SHALL cover: write x5=0xDEADBEEF, then read rs1_addr=5 -> 0xDEADBEEF; write x0=0x1234 -> rs2 at address 0 reads 0.
REQ-034 SHALL cover: reserve x3 -> rsv_ok=1, busy_cnt=1, rs1_busy=1 at address 3; reserve x3 again -> rsv_ok=0; write x3=7 -> busy clears, busy_cnt=0.
REQ-035 SHALL cover: x4 busy, with write x4=9 and reserve x4 in the same cycle -> rsv_ok=1, x4 reads 9, busy stays 1, busy_cnt unchanged.
REQ-036 SHALL cover: with the bypass macro, write x6=0xA5 while rs1_addr=6 -> rs1=0xA5 in the same cycle; without the macro -> old value, then 0xA5 next cycle.
REQ-037 SHALL cover: reserve x1, x2, x7, then assert rst_n=0 mid-clock -> busy_cnt=0 and all data 0 immediately.
